// File: rtl/vmem_host_initiator.sv
// vmem_host_initiator: valid/ready command front end driving one vmem access per command.
// Reads return odata captured RD_LAT cycles after the ren edge on a valid/ready response channel.
// Ports: clk, rst_n (async active-low); cmd_valid/cmd_ready/cmd_we/cmd_addr/cmd_wdata command in;
//   rsp_valid/rsp_ready/rsp_rdata response out; mem_addr/mem_data/mem_ren/mem_wen to memory,
//   mem_odata from memory; busy = not idle.
// Optional VMEM_HOST_CHECK_EN: shadow copy of written data flags the first read mismatch on
//   chk_err/chk_err_addr.
module vmem_host_initiator #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_we,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_ren,
   output logic              mem_wen,
   input  logic [DATA_W-1:0] mem_odata,
   output logic              busy
`ifdef VMEM_HOST_CHECK_EN
   ,
   output logic              chk_err,
   output logic [ADDR_W-1:0] chk_err_addr
`endif
);
   typedef enum logic [2:0] {IDLE, WR, RD, WAIT, RSP} state_t;
   state_t            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d, rdata_q, rdata_d;
   logic              rdy_q, busy_q, vld_q, ren_q, wen_q;
   logic              capture;
   assign capture = (state_q == WAIT) && (cnt_q == 3'd0);
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      data_d  = data_q;
      rdata_d = capture ? mem_odata : rdata_q;
      case (state_q)
         IDLE: if (cmd_valid) begin
            addr_d  = cmd_addr;
            data_d  = cmd_we ? cmd_wdata : data_q;
            state_d = cmd_we ? WR : RD;
         end
         WR:   state_d = IDLE;
         RD: begin
            cnt_d   = 3'(RD_LAT - 1);
            state_d = WAIT;
         end
         WAIT: begin
            cnt_d   = capture ? cnt_q : cnt_q - 3'd1;
            state_d = capture ? RSP : WAIT;
         end
         RSP:  state_d = rsp_ready ? IDLE : RSP;
         default: state_d = IDLE;
      endcase
   end
   // Handshake/pulse outputs are registered decodes of the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         rdata_q <= '0;
         rdy_q   <= 1'b1;
         busy_q  <= 1'b0;
         vld_q   <= 1'b0;
         ren_q   <= 1'b0;
         wen_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         rdata_q <= rdata_d;
         rdy_q   <= state_d == IDLE;
         busy_q  <= state_d != IDLE;
         vld_q   <= state_d == RSP;
         ren_q   <= state_d == RD;
         wen_q   <= state_d == WR;
      end
   end
   assign cmd_ready = rdy_q;
   assign busy      = busy_q;
   assign rsp_valid = vld_q;
   assign rsp_rdata = rdata_q;
   assign mem_addr  = addr_q;
   assign mem_data  = data_q;
   assign mem_ren   = ren_q;
   assign mem_wen   = wen_q;
`ifdef VMEM_HOST_CHECK_EN
   logic [DATA_W-1:0]      shadow_q [2**ADDR_W];
   logic [DATA_W-1:0]      shadow_d [2**ADDR_W];
   logic [2**ADDR_W-1:0]   written_q, written_d;
   logic                   err_q, err_d;
   logic [ADDR_W-1:0]      err_addr_q, err_addr_d;
   always_comb begin
      shadow_d   = shadow_q;
      written_d  = written_q;
      err_d      = err_q;
      err_addr_d = err_addr_q;
      if (state_q == WR) begin
         shadow_d[addr_q]  = data_q;
         written_d[addr_q] = 1'b1;
      end
      // Only the first mismatch is recorded; later ones leave the address alone.
      if (capture && written_q[addr_q] && (mem_odata != shadow_q[addr_q]) && !err_q) begin
         err_d      = 1'b1;
         err_addr_d = addr_q;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q   <= '{default: '0};
         written_q  <= '0;
         err_q      <= 1'b0;
         err_addr_q <= '0;
      end else begin
         shadow_q   <= shadow_d;
         written_q  <= written_d;
         err_q      <= err_d;
         err_addr_q <= err_addr_d;
      end
   end
   assign chk_err      = err_q;
   assign chk_err_addr = err_addr_q;
`endif
endmodule

// File: tb/tb_vmem_host_initiator.sv
// tb_vmem_host_initiator: scoreboard bench for two initiators (RD_LAT=1 and RD_LAT=3) each with a memory model.
module tb_vmem_host_initiator;
   typedef struct { logic [7:0] d; int c; } exp_t;
   logic       clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, cmd_we = 1'b0, rsp_ready = 1'b1;
   logic [3:0] cmd_addr = '0;
   logic [7:0] cmd_wdata = '0, corrupt_val = '0;
   logic [1:0] corrupt_en = '0;
   int         sel = 0;
   logic [1:0] cmd_ready, rsp_valid, mem_ren, mem_wen, busy;
   logic [7:0] rsp_rdata [2];
   logic [7:0] mem_data [2];
   logic [7:0] mem_odata [2];
   logic [3:0] mem_addr [2];
`ifdef VMEM_HOST_CHECK_EN
   logic [1:0] chk_err;
   logic [3:0] chk_err_addr [2];
`endif
   int   cyc = 0, checks = 0, errors = 0;
   int   ren_cnt [2], wen_cnt [2];
   logic [1:0] pvld, pren, pwen, prdy;
   logic [7:0] pdat [2];
   exp_t q0[$], q1[$];
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) prdy <= {2{rsp_ready}};
   for (genvar g = 0; g < 2; g++) begin : u
      localparam int LAT = g ? 3 : 1;
      logic [7:0] mem [16];
      logic [7:0] pd [LAT];
      logic       pv [LAT];
      vmem_host_initiator #(.ADDR_W(4), .DATA_W(8), .RD_LAT(LAT)) dut (
         .clk(clk), .rst_n(rst_n),
         .cmd_valid(cmd_valid && sel == g), .cmd_ready(cmd_ready[g]),
         .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
         .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata[g]),
         .mem_addr(mem_addr[g]), .mem_data(mem_data[g]),
         .mem_ren(mem_ren[g]), .mem_wen(mem_wen[g]), .mem_odata(mem_odata[g]),
         .busy(busy[g])
`ifdef VMEM_HOST_CHECK_EN
         , .chk_err(chk_err[g]), .chk_err_addr(chk_err_addr[g])
`endif
      );
      // Read data is valid for exactly one cycle, RD_LAT edges after the ren edge.
      always @(posedge clk) begin
         if (mem_wen[g]) mem[mem_addr[g]] <= mem_data[g];
         pv[0] <= mem_ren[g];
         pd[0] <= mem[mem_addr[g]];
         for (int k = 1; k < LAT; k++) begin
            pv[k] <= pv[k-1];
            pd[k] <= pd[k-1];
         end
      end
      assign mem_odata[g] = !pv[LAT-1] ? 8'hEE : corrupt_en[g] ? corrupt_val : pd[LAT-1];
   end
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask
   always @(negedge clk) begin
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            pvld[i] = 1'b0; pren[i] = 1'b0; pwen[i] = 1'b0;
         end else begin
            if (mem_ren[i]) ren_cnt[i]++;
            if (mem_wen[i]) wen_cnt[i]++;
            if (mem_ren[i] || mem_wen[i]) begin
               chk("ren_wen_excl", 32'(mem_ren[i] && mem_wen[i]), 0);
               chk("pulse_consec", 32'((mem_ren[i] && pren[i]) || (mem_wen[i] && pwen[i])), 0);
            end
            if (rsp_valid[i] && !pvld[i]) begin
               if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0))
                  chk("rsp_unexpected", 32'(rsp_valid[i]), 0);
               else begin
                  if (i == 0) e = q0.pop_front(); else e = q1.pop_front();
                  chk("rsp_data", 32'(rsp_rdata[i]), 32'(e.d));
                  chk("rsp_latency", 32'(cyc - e.c), (i == 1) ? 4 : 2);
               end
            end else if (rsp_valid[i])
               chk("rsp_hold", 32'(rsp_rdata[i]), 32'(pdat[i]));
            else if (pvld[i])
               chk("rsp_drop_no_ready", 32'(prdy[i]), 1);
            pvld[i] = rsp_valid[i]; pren[i] = mem_ren[i]; pwen[i] = mem_wen[i]; pdat[i] = rsp_rdata[i];
         end
      end
   end
   // For reads d is the expected response; cmd_wdata gets junk that must be ignored.
   task automatic issue(int s, bit we, logic [3:0] a, logic [7:0] d);
      int   n = 0;
      exp_t e;
      sel = s; cmd_we = we; cmd_addr = a; cmd_wdata = we ? d : ~d; cmd_valid = 1'b1;
      while (!cmd_ready[s] && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) begin
         chk("issue_timeout", 32'(cmd_ready[s]), 1);
         cmd_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      if (!we) begin
         e.d = d; e.c = cyc;
         if (s == 0) q0.push_back(e); else q1.push_back(e);
      end
      @(negedge clk);
      cmd_valid = 1'b0; cmd_addr = ~a; cmd_wdata = 8'h00;
   endtask
   task automatic drain();
      int n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) chk("drain_timeout", 32'(q0.size() + q1.size()), 0);
      @(negedge clk);
   endtask
   initial begin
      int r0, w0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'h3);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_pulses", {28'h0, mem_ren, mem_wen}, 0);
      chk("rst_addr", {24'h0, mem_addr[0], mem_addr[1]}, 0);
      chk("rst_data", {mem_data[0], mem_data[1], rsp_rdata[0], rsp_rdata[1]}, 0);
`ifdef VMEM_HOST_CHECK_EN
      chk("rst_chk_err", {22'h0, chk_err, chk_err_addr[0], chk_err_addr[1]}, 0);
`endif
      r0 = ren_cnt[0]; w0 = wen_cnt[0];
      issue(0, 1'b1, 4'd3, 8'h5A);
      issue(0, 1'b0, 4'd3, 8'h5A);
      drain();
      chk("t1_wen_cnt", 32'(wen_cnt[0] - w0), 1);
      chk("t1_ren_cnt", 32'(ren_cnt[0] - r0), 1);
      // Stall the response while cmd_valid stays high with wandering addresses.
      rsp_ready = 1'b0;
      r0 = ren_cnt[0];
      issue(0, 1'b0, 4'd3, 8'h5A);
      sel = 0; cmd_valid = 1'b1; cmd_we = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cmd_addr = 4'(8 + i);
         chk("t2_cmd_ready", 32'(cmd_ready[0]), 0);
         @(negedge clk);
      end
      chk("t2_rsp_valid", 32'(rsp_valid[0]), 1);
      chk("t2_rdata", 32'(rsp_rdata[0]), 32'h5A);
      chk("t2_ren_cnt", 32'(ren_cnt[0] - r0), 1);
      chk("t2_wen_cnt", 32'(wen_cnt[0] - w0), 1);
      cmd_valid = 1'b0; rsp_ready = 1'b1;
      @(negedge clk);
      chk("t2_idle", 32'(cmd_ready[0]), 1);
      w0 = wen_cnt[1];
      for (int a = 0; a < 16; a++) issue(1, 1'b1, 4'(a), 8'(a) ^ 8'hFF);
      for (int a = 0; a < 16; a++) issue(1, 1'b0, 4'(a), 8'(a) ^ 8'hFF);
      drain();
      chk("t3_wen_cnt", 32'(wen_cnt[1] - w0), 16);
      // Reset while the RD_LAT=3 initiator sits in WAIT.
      issue(1, 1'b0, 4'd5, 8'hFA);
      @(negedge clk);
      chk("t4_busy_before", 32'(busy[1]), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t4_busy", 32'(busy), 0);
      chk("t4_rsp_valid", 32'(rsp_valid), 0);
      chk("t4_pulses", {28'h0, mem_ren, mem_wen}, 0);
      q1.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("t4_no_rsp", 32'(rsp_valid), 0);
      chk("t4_addr_cleared", 32'(mem_addr[1]), 0);
      issue(1, 1'b0, 4'd5, 8'hFA);
      drain();
`ifdef VMEM_HOST_CHECK_EN
      corrupt_en[0] = 1'b1; corrupt_val = 8'h22;
      issue(0, 1'b1, 4'd7, 8'h11);
      issue(0, 1'b0, 4'd2, 8'h22);
      drain();
      chk("t5_unwritten_no_err", 32'(chk_err[0]), 0);
      issue(0, 1'b0, 4'd7, 8'h22);
      drain();
      chk("t5_err", 32'(chk_err[0]), 1);
      chk("t5_err_addr", 32'(chk_err_addr[0]), 7);
      issue(0, 1'b1, 4'd9, 8'h33);
      issue(0, 1'b0, 4'd9, 8'h22);
      drain();
      chk("t5_first_err_kept", 32'(chk_err_addr[0]), 7);
      corrupt_en[0] = 1'b0;
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
